// File: rtl/narrow_16b_to_8b.sv
// 16-to-8 width-down converter: 2/4-entry word FIFO followed by a byte-select FSM.
// Optional zero-extended-byte skip enabled by defining NARROW_ZSKIP_EN.
module narrow_16b_to_8b #(
  parameter int LOW_FIRST  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_word,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
    $error("narrow_16b_to_8b: FIFO_DEPTH must be 2 or 4");
  end

  typedef enum logic {FIRST, SECOND} state_t;

  state_t             state;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [15:0]        head;
  logic [7:0]         first_byte;
  logic [7:0]         second_byte;
  logic               zskip;
  logic               push;
  logic               pop;

  assign head        = mem[rd_ptr];
  assign first_byte  = (LOW_FIRST != 0) ? head[7:0]  : head[15:8];
  assign second_byte = (LOW_FIRST != 0) ? head[15:8] : head[7:0];

`ifdef NARROW_ZSKIP_EN
  // A word whose upper byte is zero is a zero-extended byte: emit only the low byte.
  assign zskip = (LOW_FIRST != 0) && (state == FIRST) && out_valid && (head[15:8] == 8'h00);
`else
  assign zskip = 1'b0;
`endif

  assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign busy      = out_valid || (state == SECOND);
  assign out_last  = (state == SECOND) || zskip;
  assign out_byte  = !out_valid        ? 8'h00 :
                     (state == SECOND) ? second_byte : first_byte;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && ((state == SECOND) || zskip);

  // NOTE: the word storage has no reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end

  // NOTE: all control state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FIRST;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (out_valid && out_ready) begin
        if (state == FIRST && !zskip) state <= SECOND;
        else                          state <= FIRST;
      end
    end
  end

endmodule

// File: tb/tb_narrow_16b_to_8b.sv
// Self-checking bench for narrow_16b_to_8b: byte scoreboard fed at push, drained at output handshake.
module tb_narrow_16b_to_8b;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;

  logic        in_valid1 = 1'b0;
  logic [15:0] in_word1 = '0;
  logic        in_ready1;
  logic        out_valid1;
  logic [7:0]  out_byte1;
  logic        out_last1;
  logic        out_ready1 = 1'b1;
  logic        busy1;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_cnt  = 0;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  narrow_16b_to_8b #(.LOW_FIRST(1), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  narrow_16b_to_8b #(.LOW_FIRST(0), .FIFO_DEPTH(DEPTH)) u_dut_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_word(in_word1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_byte(out_byte1), .out_last(out_last1),
    .out_ready(out_ready1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected byte split for the LOW_FIRST=1 instance.
  task automatic sb_push(input logic [15:0] w);
`ifdef NARROW_ZSKIP_EN
    if (w[15:8] == 8'h00) begin
      q.push_back('{b: w[7:0], last: 1'b1});
    end else begin
      q.push_back('{b: w[7:0], last: 1'b0});
      q.push_back('{b: w[15:8], last: 1'b1});
    end
`else
    q.push_back('{b: w[7:0], last: 1'b0});
    q.push_back('{b: w[15:8], last: 1'b1});
`endif
    mdl_cnt++;
  endtask

  // Compare outputs against the model, apply this cycle's handshakes, advance one clock.
  task automatic tick();
    logic exp_in_ready;
    exp_in_ready = (mdl_cnt != DEPTH);
    check("in_ready", 16'(in_ready), 16'(exp_in_ready));
    check("out_valid", 16'(out_valid), 16'(q.size() != 0));
    check("busy", 16'(busy), 16'(mdl_cnt != 0));
    if (q.size() != 0) begin
      check("out_byte", 16'(out_byte), 16'(q[0].b));
      check("out_last", 16'(out_last), 16'(q[0].last));
      if (out_ready) begin
        if (q[0].last) mdl_cnt--;
        void'(q.pop_front());
      end
    end else begin
      check("idle_byte", 16'(out_byte), 16'h0000);
      check("idle_last", 16'(out_last), 16'h0000);
    end
    if (in_valid && exp_in_ready) sb_push(in_word);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check(tag, 16'(q.size()), 16'h0000);
  endtask

  initial begin
    // Reset held: outputs at their cleared values.
    #1;
    check("rst_in_ready", 16'(in_ready), 16'h0001);
    check("rst_out_valid", 16'(out_valid), 16'h0000);
    check("rst_out_byte", 16'(out_byte), 16'h0000);
    check("rst_out_last", 16'(out_last), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Single word, downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 16'hA55A;
    tick();
    in_valid = 1'b0;
    check("a55a_b0", 16'(out_byte), 16'h005A);
    check("a55a_l0", 16'(out_last), 16'h0000);
    tick();
    check("a55a_b1", 16'(out_byte), 16'h00A5);
    check("a55a_l1", 16'(out_last), 16'h0001);
    tick();
    check("a55a_done", 16'(out_valid), 16'h0000);

    // Fill while stalled; third push must be ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 16'h1234;
    tick();
    in_word = 16'h5678;
    tick();
    check("full_in_ready", 16'(in_ready), 16'h0000);
    in_word = 16'h9999;
    tick();
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_b0", 16'(out_byte), 16'h0034);
    tick();
    check("stall_b1", 16'(out_byte), 16'h0012);
    check("still_full", 16'(in_ready), 16'h0000);
    tick();
    check("ready_after_pop", 16'(in_ready), 16'h0001);
    check("stall_b2", 16'(out_byte), 16'h0078);
    tick();
    check("stall_b3", 16'(out_byte), 16'h0056);
    tick();
    check("stall_done", 16'(out_valid), 16'h0000);

    // Random words with random backpressure across pointer wrap.
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'b1;
      in_word   = 16'($urandom);
      if ((i % 7) == 0) in_word[15:8] = 8'h00;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("rand_drain");

    // Reset while the second byte of BEEF is pending.
    in_valid  = 1'b1;
    in_word   = 16'hBEEF;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("beef_second", 16'(out_byte), 16'h00BE);
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    mdl_cnt = 0;
    check("async_out_valid", 16'(out_valid), 16'h0000);
    check("async_out_byte", 16'(out_byte), 16'h0000);
    check("async_busy", 16'(busy), 16'h0000);
    check("async_in_ready", 16'(in_ready), 16'h0001);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_word  = 16'h00C3;
    tick();
    in_valid = 1'b0;
    check("c3_first", 16'(out_byte), 16'h00C3);
`ifdef NARROW_ZSKIP_EN
    check("c3_last", 16'(out_last), 16'h0001);
`else
    check("c3_last", 16'(out_last), 16'h0000);
`endif
    drain("c3_drain");
    tick();

    // High-byte-first instance.
    in_valid1 = 1'b1;
    in_word1  = 16'hCAFE;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("cafe_b0", 16'(out_byte1), 16'h00CA);
    check("cafe_l0", 16'(out_last1), 16'h0000);
    check("cafe_busy", 16'(busy1), 16'h0001);
    @(posedge clk); #1;
    check("cafe_b1", 16'(out_byte1), 16'h00FE);
    check("cafe_l1", 16'(out_last1), 16'h0001);
    @(posedge clk); #1;
    check("cafe_done", 16'(out_valid1), 16'h0000);
    check("cafe_in_ready", 16'(in_ready1), 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/narrow_16b_to_8b.md
Name: narrow_16b_to_8b

Overview:
- Width-down converter and serializer: accepts 16-bit words on a valid/ready input and emits them as 8-bit bytes on a valid/ready output.
- It is the narrowing counterpart of the datapath's 8-to-16 zero-extend path.
- Sits between the 16-bit pipeline and byte-wide peripherals or byte-lane memory.
- Contains a 2-entry word FIFO plus a byte-select FSM, so the pipeline can hand off a word and continue while bytes drain.

Parameters:
- LOW_FIRST, 1: 1 = emit in_word[7:0] first, then [15:8]; 0 = emit [15:8] first, then [7:0].
- FIFO_DEPTH, 2: word FIFO entries. Supported values are 2 and 4. Pointers are log2(FIFO_DEPTH) bits; count is log2(FIFO_DEPTH)+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- in_valid  input  1  in_word is valid this cycle.
- in_word  input  16  word to serialize.
- in_ready  output  1  FIFO can accept a word (not full).
- out_valid  output  1  out_byte is valid.
- out_byte  output  8  current byte.
- out_last  output  1  out_byte is the final byte of its word.
- out_ready  input  1  downstream accepts out_byte this cycle.
- busy  output  1  FIFO non-empty or FSM in SECOND.

Behaviour:
- Reset values while rst=1 and after release: count=0, wr_ptr=0, rd_ptr=0, FSM=FIRST. Outputs: in_ready=1, out_valid=0, out_byte=8'h00, out_last=0, busy=0.
- Push: on a rising edge where in_valid=1 and in_ready=1, write in_word at wr_ptr, advance wr_ptr (wraps FIFO_DEPTH-1 -> 0), count+1.
- in_ready = (count != FIFO_DEPTH). It is derived from registered state only, with no combinational path from out_ready.
- A word pushed at edge N is visible on out_byte after edge N (1-cycle latency). There is no same-cycle bypass.
- out_valid = (count != 0).
- out_byte is the head word's first byte in FIRST and its second byte in SECOND. out_byte = 8'h00 when out_valid=0.
- FSM states:
  - FIRST: on out_valid and out_ready, go to SECOND. No pop.
  - SECOND: on out_ready, pop the head (rd_ptr wraps, count-1) and go to FIRST.
  - A stall (out_ready=0) holds the state, out_byte and out_last stable.
- out_last = 1 in SECOND, and 0 in FIRST except under the optional feature.
- Simultaneous push and pop in the same cycle: count unchanged and both pointers advance. This is legal when full, but in_ready=0 then, so a push on a full FIFO never occurs.
- in_valid while in_ready=0: the word is ignored and state is unchanged; upstream must hold the word.
- Throughput: 1 byte/cycle sustained, i.e. 1 word per 2 cycles. A full FIFO deasserts in_ready until the SECOND-state pop.
- Reset mid-word (FSM in SECOND): the remaining byte and all queued words are discarded. Bytes emitted after reset come only from words pushed after reset.
- busy = (count != 0) || (state == SECOND).

Optional Feature:
- Macro NARROW_ZSKIP_EN.
- Defined:
  - In FIRST with LOW_FIRST=1, if the head word[15:8] == 8'h00, the word is treated as a zero-extended byte. out_last=1 in FIRST, and acceptance pops the head and stays in FIRST, so 1 byte is emitted for that word.
  - With LOW_FIRST=0 the feature has no effect.
- Not defined: every word emits exactly 2 bytes and out_last is asserted only in SECOND.

Test Plan:
- Reset release, no traffic: in_ready=1, out_valid=0, busy=0 for 10 cycles. Assert rst mid-cycle: outputs clear without waiting for a clock edge.
- Push 16'hA55A with LOW_FIRST=1 and out_ready=1 held: bytes 8'h5A (out_last=0) then 8'hA5 (out_last=1) on consecutive cycles, then out_valid=0.
- out_ready=0, push 16'h1234 and 16'h5678: in_ready=0 after the 2nd push and a 3rd push is ignored. Then set out_ready=1: bytes 34,12,78,56 in order; in_ready reasserts after the pop of 12.
- Continuous in_valid with random words and random out_ready, 500 cycles: the byte stream equals the scoreboard split of accepted words, and no word is lost or duplicated across pointer wrap.
- Assert rst while in SECOND on word 16'hBEEF (after EF is accepted), then push 16'h00C3: next byte is 8'hC3. Without NARROW_ZSKIP_EN, C3 has out_last=0 followed by 00 with out_last=1; with it, only C3 is emitted, with out_last=1.
- LOW_FIRST=0, push 16'hCAFE: bytes CA then FE, with out_last on FE.
